seven_seg_capture: RTL and testbench

- Reader for the calculator's multiplexed 4-digit seven-segment output.
- Watches digit_select/led_select, waits for each digit to settle, then decodes its segments to a hex nibble.
- Assembles one full scan frame into a 16-bit value, with per-digit blank and error flags.
- Used in simulation benches and on-board self-check, so calculator results are compared as numbers, not waveforms.

---
 rtl/seven_seg_capture.sv | 191 +++++++++++++++++++
 tb/tb_seven_seg_capture.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_capture.sv
// Captures a multiplexed 4-digit active-low seven-segment display into a 16-bit hex frame.
// Each digit must hold steady for SETTLE_CYCLES samples; a frame is published once all four digits are captured.
module seven_seg_capture #(
    parameter int unsigned SETTLE_CYCLES  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  digit_select,
    input  logic [6:0]  led_select,
    output logic [15:0] value,
    output logic [3:0]  blank_mask,
    output logic        frame_valid,
    output logic        frame_changed,
    output logic        frame_err,
    output logic        stale
);

    localparam int unsigned CW = 8;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] SETTLE_MAX  = CW'(SETTLE_CYCLES);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {WAIT_SEL, SETTLE, HOLD} state_t;

    state_t        state;
    logic [3:0]    sel_r, sel_p;
    logic [6:0]    seg_r, seg_p;
    logic [CW-1:0] cnt;
    logic [TW-1:0] timer;
    logic [3:0]    mask;
    logic [15:0]   slot_val;
    logic [3:0]    slot_blank;
    logic [3:0]    slot_err;

    logic [3:0]    sel_hot_c;
    logic          sel_valid_c;
    logic [1:0]    sel_idx_c;
    logic          changed_c;
    logic [3:0]    nib_c;
    logic          is_blank_c;
    logic          is_err_c;
    logic          load_c;
    logic          capture_c;
    logic [3:0]    mask_next_c;
    logic [15:0]   frame_val_c;
    logic [3:0]    frame_blank_c;
    logic [3:0]    frame_err_c;

    // Select qualification: exactly one anode driven low.
    always_comb begin
        sel_hot_c   = ~sel_r;
        sel_valid_c = 1'b1;
        sel_idx_c   = 2'd0;
        case (sel_hot_c)
            4'b0001: sel_idx_c = 2'd0;
            4'b0010: sel_idx_c = 2'd1;
            4'b0100: sel_idx_c = 2'd2;
            4'b1000: sel_idx_c = 2'd3;
            default: sel_valid_c = 1'b0;
        endcase
        changed_c = (sel_r != sel_p) || (seg_r != seg_p);
    end

    // Segment pattern to hex nibble; blank and undecodable patterns read as 0.
    always_comb begin
        nib_c      = 4'h0;
        is_blank_c = 1'b0;
        is_err_c   = 1'b0;
        case (seg_r)
            7'h40: nib_c = 4'h0;
            7'h79: nib_c = 4'h1;
            7'h24: nib_c = 4'h2;
            7'h30: nib_c = 4'h3;
            7'h19: nib_c = 4'h4;
            7'h12: nib_c = 4'h5;
            7'h02: nib_c = 4'h6;
            7'h78: nib_c = 4'h7;
            7'h00: nib_c = 4'h8;
            7'h10: nib_c = 4'h9;
            7'h08: nib_c = 4'hA;
            7'h03: nib_c = 4'hB;
            7'h46: nib_c = 4'hC;
            7'h21: nib_c = 4'hD;
            7'h06: nib_c = 4'hE;
            7'h0E: nib_c = 4'hF;
            7'h7F: is_blank_c = 1'b1;
            default: is_err_c = 1'b1;
        endcase
    end

    // A fresh valid select (re)starts settling; with SETTLE_CYCLES=1 the first sample suffices.
    always_comb begin
        load_c    = 1'b0;
        capture_c = 1'b0;
        case (state)
            WAIT_SEL: load_c = sel_valid_c;
            SETTLE: begin
                if (changed_c) load_c = sel_valid_c;
                else           capture_c = (cnt + CW'(1)) >= SETTLE_MAX;
            end
            HOLD:     load_c = changed_c && sel_valid_c;
            default:  load_c = 1'b0;
        endcase
        if (load_c && (SETTLE_CYCLES == 1)) capture_c = 1'b1;
    end

    // Frame contents as they would look with the current capture merged in.
    always_comb begin
        mask_next_c   = mask;
        frame_val_c   = slot_val;
        frame_blank_c = slot_blank;
        frame_err_c   = slot_err;
        mask_next_c[sel_idx_c]             = 1'b1;
        frame_val_c[{sel_idx_c, 2'b00} +: 4] = nib_c;
        frame_blank_c[sel_idx_c]           = is_blank_c;
        frame_err_c[sel_idx_c]             = is_err_c;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_r <= 4'hF;
            seg_r <= 7'h7F;
            sel_p <= 4'hF;
            seg_p <= 7'h7F;
        end else begin
            sel_r <= digit_select;
            seg_r <= led_select;
            sel_p <= sel_r;
            seg_p <= seg_r;
        end
    end

    // Settle FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= WAIT_SEL;
            cnt   <= '0;
        end else begin
            if (load_c)                  cnt <= CW'(1);
            else if (state == SETTLE)    cnt <= cnt + CW'(1);
            if (capture_c)               state <= HOLD;
            else if (load_c)             state <= SETTLE;
            else if (state != WAIT_SEL && changed_c) state <= WAIT_SEL;
        end
    end

    // Slot assembly, frame publication and staleness timer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask          <= '0;
            slot_val      <= '0;
            slot_blank    <= '0;
            slot_err      <= '0;
            timer         <= '0;
            value         <= '0;
            blank_mask    <= 4'hF;
            frame_valid   <= 1'b0;
            frame_changed <= 1'b0;
            frame_err     <= 1'b0;
            stale         <= 1'b0;
        end else begin
            frame_valid   <= 1'b0;
            frame_changed <= 1'b0;
            if (capture_c) begin
                slot_val   <= frame_val_c;
                slot_blank <= frame_blank_c;
                slot_err   <= frame_err_c;
                timer      <= '0;
                stale      <= 1'b0;
                if (mask_next_c == 4'hF) begin
                    mask          <= '0;
                    value         <= frame_val_c;
                    blank_mask    <= frame_blank_c;
                    frame_err     <= |frame_err_c;
                    frame_valid   <= 1'b1;
                    frame_changed <= {frame_val_c, frame_blank_c} != {value, blank_mask};
                end else begin
                    mask <= mask_next_c;
                end
            end else if (timer != TIMEOUT_MAX) begin
                timer <= timer + TW'(1);
                if ((timer + TW'(1)) == TIMEOUT_MAX) begin
                    mask  <= '0;
                    stale <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture: table of full scans plus hand-written timeout and reset sequences.
module tb_seven_seg_capture;

    localparam int unsigned TO = 1024;

    logic        clk;
    logic        reset;
    logic [3:0]  digit_select;
    logic [6:0]  led_select;
    logic [15:0] value;
    logic [3:0]  blank_mask;
    logic        frame_valid;
    logic        frame_changed;
    logic        frame_err;
    logic        stale;

    int checks   = 0;
    int failures = 0;

    seven_seg_capture #(.SETTLE_CYCLES(2), .TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .digit_select  (digit_select),
        .led_select    (led_select),
        .value         (value),
        .blank_mask    (blank_mask),
        .frame_valid   (frame_valid),
        .frame_changed (frame_changed),
        .frame_err     (frame_err),
        .stale         (stale)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor: counts frame_valid pulses and snapshots the published frame.
    int          pulse_cnt = 0;
    logic [15:0] snap_value;
    logic [3:0]  snap_blank;
    logic        snap_err;
    logic        snap_changed;
    always @(negedge clk) begin
        if (frame_valid) begin
            pulse_cnt    = pulse_cnt + 1;
            snap_value   = value;
            snap_blank   = blank_mask;
            snap_err     = frame_err;
            snap_changed = frame_changed;
        end
    end

    typedef struct {
        logic [3:0][6:0] segs;
        logic [15:0]     exp_value;
        logic [3:0]      exp_blank;
        logic            exp_err;
        logic            exp_changed;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_digit(input int d, input logic [6:0] seg, input int n);
        digit_select = 4'(~(4'b0001 << d));
        led_select   = seg;
        cyc(n);
    endtask

    task automatic idle(input int n);
        digit_select = 4'hF;
        led_select   = 7'h7F;
        cyc(n);
    endtask

    task automatic scan(input logic [3:0][6:0] segs);
        for (int d = 3; d >= 0; d--) drive_digit(d, segs[d], 8);
        idle(4);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_value"},   32'(value),         32'h0);
        check({tag, "_blank"},   32'(blank_mask),    32'hF);
        check({tag, "_valid"},   32'(frame_valid),   32'h0);
        check({tag, "_changed"}, 32'(frame_changed), 32'h0);
        check({tag, "_err"},     32'(frame_err),     32'h0);
        check({tag, "_stale"},   32'(stale),         32'h0);
    endtask

    initial begin
        int base;
        int waited;
        vecs[0] = '{'{7'h79, 7'h08, 7'h30, 7'h0E}, 16'h1A3F, 4'b0000, 1'b0, 1'b1};
        vecs[1] = '{'{7'h79, 7'h08, 7'h30, 7'h0E}, 16'h1A3F, 4'b0000, 1'b0, 1'b0};
        vecs[2] = '{'{7'h7F, 7'h7F, 7'h30, 7'h40}, 16'h0030, 4'b1100, 1'b0, 1'b1};
        vecs[3] = '{'{7'h79, 7'h55, 7'h30, 7'h0E}, 16'h103F, 4'b0000, 1'b1, 1'b1};
        vecs[4] = '{'{7'h79, 7'h08, 7'h30, 7'h0E}, 16'h1A3F, 4'b0000, 1'b0, 1'b1};
        vecs[5] = '{'{7'h24, 7'h46, 7'h21, 7'h06}, 16'h2CDE, 4'b0000, 1'b0, 1'b1};
        vecs[6] = '{'{7'h02, 7'h78, 7'h00, 7'h10}, 16'h6789, 4'b0000, 1'b0, 1'b1};
        vecs[7] = '{'{7'h40, 7'h19, 7'h12, 7'h03}, 16'h045B, 4'b0000, 1'b0, 1'b1};

        reset        = 1'b1;
        digit_select = 4'hF;
        led_select   = 7'h7F;
        cyc(3);
        check_reset_outputs("por");
        reset = 1'b0;
        idle(2);

        for (int i = 0; i < 8; i++) begin
            base = pulse_cnt;
            scan(vecs[i].segs);
            check($sformatf("vec%0d_pulses", i), 32'(pulse_cnt - base), 32'd1);
            check($sformatf("vec%0d_value", i),  32'(snap_value),   32'(vecs[i].exp_value));
            check($sformatf("vec%0d_blank", i),  32'(snap_blank),   32'(vecs[i].exp_blank));
            check($sformatf("vec%0d_err", i),    32'(snap_err),     32'(vecs[i].exp_err));
            check($sformatf("vec%0d_chg", i),    32'(snap_changed), 32'(vecs[i].exp_changed));
            check($sformatf("vec%0d_stale", i),  32'(stale),        32'h0);
        end

        // Unsettled digits and a multi-hot select never capture; the display goes stale.
        base = pulse_cnt;
        for (int r = 0; r < 10; r++)
            for (int d = 3; d >= 0; d--) drive_digit(d, 7'h30, 1);
        digit_select = 4'b1100;
        led_select   = 7'h30;
        waited = 0;
        while (!stale && waited < TO + 50) begin
            cyc(1);
            waited++;
        end
        check("short_stale",  32'(stale),            32'h1);
        check("short_pulses", 32'(pulse_cnt - base), 32'h0);
        check("short_value",  32'(value),            32'h045B);

        // Partial frame abandoned by timeout is discarded.
        base = pulse_cnt;
        drive_digit(3, 7'h46, 8);
        check("partial_stale_clr", 32'(stale), 32'h0);
        drive_digit(2, 7'h40, 8);
        drive_digit(1, 7'h21, 8);
        idle(1000);
        check("partial_not_stale", 32'(stale), 32'h0);
        waited = 0;
        while (!stale && waited < 100) begin
            cyc(1);
            waited++;
        end
        check("partial_stale", 32'(stale),            32'h1);
        check("partial_value", 32'(value),            32'h045B);
        check("partial_pulse", 32'(pulse_cnt - base), 32'h0);
        drive_digit(0, 7'h06, 8);
        idle(4);
        check("discard_pulse", 32'(pulse_cnt - base), 32'h0);
        check("discard_stale", 32'(stale),            32'h0);
        scan('{7'h46, 7'h40, 7'h21, 7'h06});
        check("restart_pulse", 32'(pulse_cnt - base), 32'h1);
        check("restart_value", 32'(snap_value),       32'hC0DE);
        check("restart_chg",   32'(snap_changed),     32'h1);
        check("restart_stale", 32'(stale),            32'h0);

        // Asynchronous reset mid-frame.
        drive_digit(3, 7'h79, 8);
        drive_digit(2, 7'h08, 4);
        reset = 1'b1;
        #2;
        check_reset_outputs("midrst");
        cyc(3);
        check_reset_outputs("midrst_hold");
        reset = 1'b0;
        base = pulse_cnt;
        scan('{7'h79, 7'h08, 7'h30, 7'h0E});
        check("post_rst_pulse", 32'(pulse_cnt - base), 32'h1);
        check("post_rst_value", 32'(snap_value),       32'h1A3F);
        check("post_rst_blank", 32'(snap_blank),       32'h0);
        check("post_rst_chg",   32'(snap_changed),     32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
